// File: rtl/spi_slave_regfile_if.sv
// SPI pin bundle between the configuration-bus master and the responder.
// Ports: SCLK, SS_N, MOSI driven by master; MISO driven by slave.
interface spi_slave_regfile_if;
   logic SCLK;
   logic SS_N;
   logic MOSI;
   logic MISO;

   modport master (
      output SCLK,
      output SS_N,
      output MOSI,
      input  MISO
   );

   modport slave (
      input  SCLK,
      input  SS_N,
      input  MOSI,
      output MISO
   );
endinterface

// File: rtl/spi_slave_regfile.sv
// SPI responder with a local 16-bit register bank, oversampled on clk_input.
// Ports: clk_input, reset (async, high), spi (slave modport), write/read
// strobes with address/data, frame_err, busy, host read port.
module spi_slave_regfile #(
   parameter int REG_DEPTH = 64,
   parameter int READ_GAP  = 2
) (
   input  logic                 clk_input,
   input  logic                 reset,
   spi_slave_regfile_if.slave   spi,
   output logic                 wr_strobe,
   output logic [8:0]           wr_addr,
   output logic [15:0]          wr_data,
   output logic                 rd_strobe,
   output logic [8:0]           rd_addr,
   output logic                 frame_err,
   output logic                 busy,
   input  logic [8:0]           host_addr,
   output logic [15:0]          host_rdata
);

   localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
   localparam logic [9:0] DEPTH10 = 10'(REG_DEPTH);

   localparam logic [5:0] CMD_LAST = 6'd9;
   localparam logic [5:0] WR_END   = 6'd25;
   localparam logic [5:0] WR_LAST  = 6'd26;
   localparam logic [5:0] GAP_END  = 6'(10 + READ_GAP);
   localparam logic [5:0] RD_LAST  = 6'(26 + READ_GAP);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] CMD   = 3'd1;
   localparam logic [2:0] GAP   = 3'd2;
   localparam logic [2:0] WDATA = 3'd3;
   localparam logic [2:0] RDATA = 3'd4;
   localparam logic [2:0] DONE  = 3'd5;

   logic [2:0]  sclk_q;
   logic [2:0]  ss_q;
   logic [1:0]  mosi_q;
   logic        sclk_rise;
   logic        sclk_fall;
   logic        ss_rise;
   logic        ss_fall;
   logic        mosi_s;

   logic [2:0]  state;
   logic [5:0]  bit_cnt;
   logic [8:0]  cmd_shift;
   logic [14:0] wr_shift;
   logic [15:0] rd_shift;
   logic [3:0]  rd_cnt;
   logic [8:0]  addr;
   logic        rw;
   logic        miso_q;

   logic [15:0] regs [REG_DEPTH];

   logic [9:0]  cmd_next;
   logic [8:0]  cmd_addr;
   logic [15:0] cmd_rdata;
   logic [15:0] wr_next;
   logic        addr_ok;
   logic        host_ok;

   // SS_N stages reset low so a select already low at reset release
   // cannot look like a fall until a high sample has been seen.
   always_ff @(posedge clk_input or posedge reset) begin
      if (reset) begin
         sclk_q <= '0;
         ss_q   <= '0;
         mosi_q <= '0;
      end else begin
         sclk_q <= {sclk_q[1:0], spi.SCLK};
         ss_q   <= {ss_q[1:0], spi.SS_N};
         mosi_q <= {mosi_q[0], spi.MOSI};
      end
   end

   assign sclk_rise = sclk_q[1] & ~sclk_q[2];
   assign sclk_fall = ~sclk_q[1] & sclk_q[2];
   assign ss_rise   = ss_q[1] & ~ss_q[2];
   assign ss_fall   = ~ss_q[1] & ss_q[2];
   assign mosi_s    = mosi_q[1];

   always_comb begin
      cmd_next  = {cmd_shift, mosi_s};
      cmd_addr  = cmd_next[9:1];
      wr_next   = {wr_shift, mosi_s};
      addr_ok   = ({1'b0, addr} < DEPTH10);
      host_ok   = ({1'b0, host_addr} < DEPTH10);
      cmd_rdata = '0;
      if ({1'b0, cmd_addr} < DEPTH10)
         cmd_rdata = regs[cmd_addr[AW-1:0]];
   end

   assign spi.MISO = miso_q;

   always_ff @(posedge clk_input or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         cmd_shift <= '0;
         wr_shift  <= '0;
         rd_shift  <= '0;
         rd_cnt    <= '0;
         addr      <= '0;
         rw        <= 1'b0;
         miso_q    <= 1'b0;
         busy      <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         rd_strobe <= 1'b0;
         rd_addr   <= '0;
         frame_err <= 1'b0;
         for (int i = 0; i < REG_DEPTH; i++)
            regs[i] <= '0;
      end else begin
         wr_strobe <= 1'b0;
         rd_strobe <= 1'b0;
         frame_err <= 1'b0;

         if (state == IDLE)
            bit_cnt <= '0;
         else if (sclk_rise && !ss_q[1] && bit_cnt != 6'd63)
            bit_cnt <= bit_cnt + 6'd1;

         unique case (state)
            IDLE: begin
               if (ss_fall) begin
                  state <= CMD;
                  busy  <= 1'b1;
               end
            end
            CMD: begin
               if (ss_rise) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  miso_q    <= 1'b0;
                  frame_err <= 1'b1;
               end else if (sclk_rise) begin
                  cmd_shift <= cmd_next[8:0];
                  if (bit_cnt == CMD_LAST) begin
                     addr <= cmd_addr;
                     rw   <= cmd_next[0];
                     if (cmd_next[0]) begin
                        state <= WDATA;
                     end else begin
                        rd_strobe <= 1'b1;
                        rd_addr   <= cmd_addr;
                        rd_shift  <= cmd_rdata;
                        rd_cnt    <= '0;
                        state     <= (READ_GAP == 0) ? RDATA : GAP;
                     end
                  end
               end
            end
            GAP: begin
               if (ss_rise) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  miso_q    <= 1'b0;
                  frame_err <= 1'b1;
               end else if (bit_cnt == GAP_END) begin
                  state <= RDATA;
               end
            end
            RDATA: begin
               if (ss_rise) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  miso_q    <= 1'b0;
                  frame_err <= 1'b1;
               end else if (sclk_fall) begin
                  miso_q   <= rd_shift[15];
                  rd_shift <= {rd_shift[14:0], 1'b0};
                  rd_cnt   <= rd_cnt + 4'd1;
                  // last bit stays on MISO until the next fall in DONE
                  if (rd_cnt == 4'd15)
                     state <= DONE;
               end
            end
            WDATA: begin
               if (ss_rise) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  miso_q    <= 1'b0;
                  frame_err <= 1'b1;
               end else if (sclk_rise) begin
                  wr_shift <= wr_next[14:0];
                  if (bit_cnt == WR_END) begin
                     if (addr_ok) begin
                        regs[addr[AW-1:0]] <= wr_next;
                        wr_strobe <= 1'b1;
                        wr_addr   <= addr;
                        wr_data   <= wr_next;
                     end
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               if (ss_rise) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  miso_q    <= 1'b0;
                  frame_err <= rw ? (bit_cnt > WR_LAST)
                                  : (bit_cnt > RD_LAST);
               end else if (sclk_fall) begin
                  miso_q <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Same-cycle SPI write shows here one cycle later (old value first).
   always_ff @(posedge clk_input or posedge reset) begin
      if (reset)
         host_rdata <= '0;
      else if (host_ok)
         host_rdata <= regs[host_addr[AW-1:0]];
      else
         host_rdata <= '0;
   end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile: writes, reads, aborts, reset.
// Drives SCLK at 1/8 of clk_input and samples MISO on SCLK rises.
`timescale 1ns/1ps
module tb_spi_slave_regfile;

   logic        clk_input = 1'b0;
   logic        reset;
   logic        wr_strobe;
   logic [8:0]  wr_addr;
   logic [15:0] wr_data;
   logic        rd_strobe;
   logic [8:0]  rd_addr;
   logic        frame_err;
   logic        busy;
   logic [8:0]  host_addr;
   logic [15:0] host_rdata;

   int checks = 0;
   int errors = 0;

   int wr_cnt = 0;
   int rd_cnt = 0;
   int err_cnt = 0;
   logic [8:0]  wlog_a [16];
   logic [15:0] wlog_d [16];
   logic [8:0]  rd_last = '0;

   spi_slave_regfile_if bus ();

   spi_slave_regfile dut (
      .clk_input  (clk_input),
      .reset      (reset),
      .spi        (bus),
      .wr_strobe  (wr_strobe),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_strobe  (rd_strobe),
      .rd_addr    (rd_addr),
      .frame_err  (frame_err),
      .busy       (busy),
      .host_addr  (host_addr),
      .host_rdata (host_rdata)
   );

   always #5 clk_input = ~clk_input;

   always @(negedge clk_input) begin
      if (wr_strobe) begin
         if (wr_cnt < 16) begin
            wlog_a[wr_cnt] = wr_addr;
            wlog_d[wr_cnt] = wr_data;
         end
         wr_cnt++;
      end
      if (rd_strobe) begin
         rd_last = rd_addr;
         rd_cnt++;
      end
      if (frame_err)
         err_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic frame(input logic [9:0] cmd, input logic [15:0] data,
                        input int nrise, input bit raise_ss,
                        output logic [15:0] cap, output int miso_bad);
      logic s;
      cap = '0;
      miso_bad = 0;
      bus.SS_N = 1'b0;
      #100;
      for (int i = 0; i < nrise; i++) begin
         if (i < 10)
            bus.MOSI = cmd[9-i];
         else if (i < 26)
            bus.MOSI = data[25-i];
         else
            bus.MOSI = 1'b0;
         #40;
         bus.SCLK = 1'b1;
         s = bus.MISO;
         if (i >= 12 && i < 28)
            cap = {cap[14:0], s};
         else if (s !== 1'b0)
            miso_bad++;
         #40;
         bus.SCLK = 1'b0;
      end
      if (raise_ss) begin
         #100;
         bus.SS_N = 1'b1;
         #160;
      end
   endtask

   task automatic host_read(input logic [8:0] a, output logic [15:0] d);
      host_addr = a;
      #20;
      d = host_rdata;
   endtask

   initial begin
      logic [15:0] cap;
      logic [15:0] hd;
      int bad;
      int w0;
      int e0;
      int r0;

      bus.SCLK  = 1'b0;
      bus.SS_N  = 1'b1;
      bus.MOSI  = 1'b0;
      host_addr = '0;
      reset     = 1'b1;
      #33;
      check("rst_miso", 32'(bus.MISO), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_wr_strobe", 32'(wr_strobe), 0);
      check("rst_rd_strobe", 32'(rd_strobe), 0);
      check("rst_frame_err", 32'(frame_err), 0);
      check("rst_wr_addr", 32'(wr_addr), 0);
      check("rst_wr_data", 32'(wr_data), 0);
      check("rst_rd_addr", 32'(rd_addr), 0);
      check("rst_host_rdata", 32'(host_rdata), 0);
      #70;
      reset = 1'b0;
      #100;

      // write 0x005 = 0xA5C3
      frame(10'b0000001011, 16'hA5C3, 26, 1'b1, cap, bad);
      check("w5_strobes", 32'(wr_cnt), 1);
      check("w5_log_addr", 32'(wlog_a[0]), 32'h005);
      check("w5_log_data", 32'(wlog_d[0]), 32'hA5C3);
      check("w5_wr_addr", 32'(wr_addr), 32'h005);
      check("w5_wr_data", 32'(wr_data), 32'hA5C3);
      check("w5_frame_err", 32'(err_cnt), 0);
      check("w5_busy", 32'(busy), 0);
      check("w5_miso", 32'(bad), 0);
      host_read(9'h005, hd);
      check("w5_host", 32'(hd), 32'hA5C3);

      // read 0x005
      frame(10'b0000001010, 16'h0000, 28, 1'b1, cap, bad);
      check("r5_strobes", 32'(rd_cnt), 1);
      check("r5_rd_addr", 32'(rd_last), 32'h005);
      check("r5_data", 32'(cap), 32'hA5C3);
      check("r5_miso_outside", 32'(bad), 0);
      check("r5_miso_after", 32'(bus.MISO), 0);
      check("r5_frame_err", 32'(err_cnt), 0);

      // out-of-range write then read of 0x1FF
      frame(10'h3FF, 16'hFFFF, 26, 1'b1, cap, bad);
      check("w1ff_no_strobe", 32'(wr_cnt), 1);
      frame(10'h3FE, 16'h0000, 28, 1'b1, cap, bad);
      check("r1ff_strobes", 32'(rd_cnt), 2);
      check("r1ff_rd_addr", 32'(rd_last), 32'h1FF);
      check("r1ff_data", 32'(cap), 0);
      check("r1ff_frame_err", 32'(err_cnt), 0);
      host_read(9'h1FF, hd);
      check("r1ff_host", 32'(hd), 0);

      // short write to addr 3
      frame(10'b0000000111, 16'h7777, 20, 1'b1, cap, bad);
      check("short_frame_err", 32'(err_cnt), 1);
      check("short_no_strobe", 32'(wr_cnt), 1);
      check("short_busy", 32'(busy), 0);
      host_read(9'h003, hd);
      check("short_reg3", 32'(hd), 0);
      frame(10'b0000000111, 16'h3C3C, 26, 1'b1, cap, bad);
      check("after_short_strobes", 32'(wr_cnt), 2);
      check("after_short_addr", 32'(wlog_a[1]), 32'h003);
      host_read(9'h003, hd);
      check("after_short_reg3", 32'(hd), 32'h3C3C);
      check("after_short_err", 32'(err_cnt), 1);

      // reset at bit 15 of a write to addr 1, SS_N held low
      w0 = wr_cnt;
      frame(10'b0000000011, 16'hBEEF, 15, 1'b0, cap, bad);
      check("mid_busy", 32'(busy), 1);
      reset = 1'b1;
      #20;
      check("mrst_busy", 32'(busy), 0);
      check("mrst_wr_addr", 32'(wr_addr), 0);
      check("mrst_wr_data", 32'(wr_data), 0);
      check("mrst_rd_addr", 32'(rd_addr), 0);
      check("mrst_miso", 32'(bus.MISO), 0);
      check("mrst_host", 32'(host_rdata), 0);
      host_addr = 9'h005;
      #20;
      reset = 1'b0;
      #200;
      check("mrst_wait_high", 32'(busy), 0);
      check("mrst_reg5", 32'(host_rdata), 0);
      check("mrst_no_strobe", 32'(wr_cnt), 32'(w0));
      bus.SS_N = 1'b1;
      #200;
      frame(10'b0000000011, 16'h1234, 26, 1'b1, cap, bad);
      check("rt1_strobes", 32'(wr_cnt), 32'(w0 + 1));
      check("rt1_wr_data", 32'(wr_data), 32'h1234);
      frame(10'b0000000010, 16'h0000, 28, 1'b1, cap, bad);
      check("rt1_read", 32'(cap), 32'h1234);

      // back-to-back writes 0x010 and 0x011
      w0 = wr_cnt;
      e0 = err_cnt;
      frame(10'b0000100001, 16'h0001, 26, 1'b1, cap, bad);
      frame(10'b0000100011, 16'h8000, 26, 1'b1, cap, bad);
      check("b2b_strobes", 32'(wr_cnt), 32'(w0 + 2));
      check("b2b_addr0", 32'(wlog_a[w0]), 32'h010);
      check("b2b_data0", 32'(wlog_d[w0]), 32'h0001);
      check("b2b_addr1", 32'(wlog_a[w0+1]), 32'h011);
      check("b2b_data1", 32'(wlog_d[w0+1]), 32'h8000);
      host_read(9'h010, hd);
      check("b2b_reg10", 32'(hd), 32'h0001);
      host_read(9'h011, hd);
      check("b2b_reg11", 32'(hd), 32'h8000);
      r0 = rd_cnt;
      frame(10'b0000100010, 16'h0000, 28, 1'b1, cap, bad);
      check("b2b_readback", 32'(cap), 32'h8000);
      check("b2b_rd_strobe", 32'(rd_cnt), 32'(r0 + 1));
      check("b2b_no_err", 32'(err_cnt), 32'(e0));

      // 30 extra rises on a write to 0x012
      frame(10'b0000100101, 16'h5A5A, 56, 1'b1, cap, bad);
      check("long_frame_err", 32'(err_cnt), 32'(e0 + 1));
      check("long_strobes", 32'(wr_cnt), 32'(w0 + 3));
      host_read(9'h012, hd);
      check("long_reg12", 32'(hd), 32'h5A5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
